// File: rtl/seven_seg_pkg.sv
// Shared glyph table, mode codes, FSM state and BCD sizing for the seven-segment bank.
// Glyphs are active-high with bit6=g down to bit0=a; polarity is applied at the output register.
package seven_seg_pkg;

  // Element [0] is the rightmost entry: glyphs for 0..9, A, b, C, d, E, F.
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic MODE_HEX = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic {IDLE, CONV} state_t;

  function automatic int bcd_digits(input int data_w);
    return (data_w * 301) / 1000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one data bit per cycle, DATA_W cycles from start to done.
// done_o is high during the final CONV cycle, with bcd_o carrying the value that cycle produces.
module bin2bcd_seq
  import seven_seg_pkg::*;
#(
  parameter int DATA_W     = 27,
  parameter int BCD_DIGITS = bcd_digits(DATA_W)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [DATA_W-1:0]       data_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [BCD_DIGITS*4-1:0] bcd_o
);

  localparam int BW = BCD_DIGITS * 4;
  localparam int CW = $clog2(DATA_W);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic [BW-1:0]     bcd_q, bcd_adj, bcd_step;
  logic              last;

  assign last = (cnt_q == CW'(DATA_W - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = CONV;
      CONV:    if (last)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state_q == CONV);
    done_o = (state_q == CONV) && last;
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    bcd_step = {bcd_adj[BW-2:0], sh_q[DATA_W-1]};
  end

  assign bcd_o = bcd_step;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sh_q  <= '0;
      bcd_q <= '0;
    end else if (state_q == IDLE) begin
      if (start_i) begin
        cnt_q <= '0;
        sh_q  <= data_i;
        bcd_q <= '0;
      end
    end else begin
      cnt_q <= cnt_q + 1'b1;
      sh_q  <= sh_q << 1;
      bcd_q <= bcd_step;
    end
  end

endmodule

// File: rtl/seven_seg_bank.sv
// Binary value to NUM_DIGITS seven-segment digits (hex immediate, decimal via bin2bcd_seq).
// Registered output; writes arriving while busy are dropped and flagged on wr_drop.
module seven_seg_bank
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W     = 27,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    wr_mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    busy,
  output logic                    overflow,
  output logic                    wr_drop,
  output logic [7*NUM_DIGITS-1:0] seg_out
);

  localparam int BCD_DIGITS = bcd_digits(DATA_W);
  localparam int DW         = 4 * NUM_DIGITS;
  localparam int BW         = 4 * BCD_DIGITS;
  localparam int SEG_W      = 7 * NUM_DIGITS;
  localparam int BLK_W      = $clog2(BLINK_DIV);
  localparam logic [SEG_W-1:0] SEG_OFF = (ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  logic              eng_start, eng_busy, eng_done, accept, ovf_res;
  logic [BW-1:0]     eng_bcd;
  logic [DW-1:0]     hex_dig, dec_dig;
  logic [DW-1:0]     dig_q, dig_d;
  logic              blank_all_q, blank_all_d, ovf_q, ovf_d, drop_q, blk_ph_q;
  logic [BLK_W-1:0]  blk_cnt_q;
  logic [SEG_W-1:0]  seg_q, seg_d;

  assign accept    = wr_en && !eng_busy;
  assign eng_start = accept && (wr_mode == MODE_DEC);

  bin2bcd_seq #(.DATA_W(DATA_W), .BCD_DIGITS(BCD_DIGITS)) u_bcd (
    .clk_i  (clk_clk),
    .rst_i  (reset_reset),
    .start_i(eng_start),
    .data_i (wr_data),
    .busy_o (eng_busy),
    .done_o (eng_done),
    .bcd_o  (eng_bcd)
  );

  generate
    if (DATA_W >= DW) begin : g_hex_trunc
      assign hex_dig = wr_data[DW-1:0];
    end else begin : g_hex_ext
      assign hex_dig = DW'(wr_data);
    end
    if (BW > DW) begin : g_ovf
      assign dec_dig = eng_bcd[DW-1:0];
      assign ovf_res = |eng_bcd[BW-1:DW];
    end else begin : g_no_ovf
      assign dec_dig = DW'(eng_bcd);
      assign ovf_res = 1'b0;
    end
  endgenerate

  always_comb begin
    dig_d       = dig_q;
    blank_all_d = blank_all_q;
    ovf_d       = ovf_q;
    if (accept && wr_mode == MODE_HEX) begin
      dig_d       = hex_dig;
      blank_all_d = 1'b0;
      ovf_d       = 1'b0;
    end else if (eng_done) begin
      dig_d       = dec_dig;
      blank_all_d = 1'b0;
      ovf_d       = ovf_res;
    end
  end

  // Scan from the top digit so nz_seen marks everything at or below the leading nonzero digit.
  always_comb begin : disp
    logic       nz_seen;
    logic [3:0] nib;
    logic [6:0] g;
    nz_seen = 1'b0;
    nib     = '0;
    g       = SEG_BLANK;
    seg_d   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib     = dig_q[4*i +: 4];
      nz_seen = nz_seen || (nib != 4'd0);
      g       = SEG_GLYPH[nib];
      if (ovf_q)                              g = SEG_DASH;
      else if (blank_lz && !nz_seen && i != 0) g = SEG_BLANK;
      if (blank_all_q || (blk_ph_q && blink_mask[i])) g = SEG_BLANK;
      seg_d[7*i +: 7] = (ACTIVE_LOW != 0) ? ~g : g;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      dig_q       <= '0;
      blank_all_q <= 1'b1;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
      blk_cnt_q   <= '0;
      blk_ph_q    <= 1'b0;
      seg_q       <= SEG_OFF;
    end else begin
      dig_q       <= dig_d;
      blank_all_q <= blank_all_d;
      ovf_q       <= ovf_d;
      drop_q      <= wr_en && eng_busy;
      seg_q       <= seg_d;
      if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt_q <= '0;
        blk_ph_q  <= ~blk_ph_q;
      end else begin
        blk_cnt_q <= blk_cnt_q + 1'b1;
      end
    end
  end

  assign busy     = eng_busy;
  assign overflow = ovf_q;
  assign wr_drop  = drop_q;
  assign seg_out  = seg_q;

endmodule

// File: tb/tb_seven_seg_bank.sv
// Directed and randomized checks of seven_seg_bank against an arithmetic display model.
module tb_seven_seg_bank;

  localparam int ND = 8;
  localparam int DW = 27;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          wr_mode = 1'b0;
  logic          blank_lz = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [ND-1:0] blink_mask = '0;
  wire           busy, overflow, wr_drop;
  wire  [7*ND-1:0] seg_out;

  int checks = 0;
  int failures = 0;
  int unsigned nedge;

  logic [63:0] m_val;
  bit          m_dec, m_valid;
  logic [6:0]  gl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seven_seg_bank #(.NUM_DIGITS(ND), .DATA_W(DW), .BLINK_DIV(4), .ACTIVE_LOW(1)) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .wr_mode    (wr_mode),
    .blank_lz   (blank_lz),
    .blink_mask (blink_mask),
    .busy       (busy),
    .overflow   (overflow),
    .wr_drop    (wr_drop),
    .seg_out    (seg_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) nedge <= 0;
    else     nedge <= nedge + 1;
  end

  function automatic bit m_ovf();
    return m_valid && m_dec && (m_val >= 64'd100000000);
  endfunction

  // Output after edge k reflects blink phase after k-1 edges; phase = floor(edges/4) mod 2.
  function automatic logic [7*ND-1:0] model_seg();
    logic [7*ND-1:0] s;
    logic [63:0] p, base, d;
    logic [6:0]  g;
    bit ph;
    ph   = (nedge == 0) ? 1'b0 : ((((nedge - 1) / 4) % 2) == 1);
    base = m_dec ? 64'd10 : 64'd16;
    p    = 64'd1;
    s    = '0;
    for (int i = 0; i < ND; i++) begin
      d = (m_val / p) % base;
      g = gl[d[3:0]];
      if (m_ovf()) g = 7'h40;
      else if (blank_lz && i > 0 && m_val < p) g = 7'h00;
      if (!m_valid || (ph && blink_mask[i])) g = 7'h00;
      s[7*i +: 7] = ~g;
      p = p * base;
    end
    return s;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_hex(input logic [DW-1:0] v);
    wr_data = v; wr_mode = 1'b0; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    m_val = 64'(v); m_dec = 1'b0; m_valid = 1'b1;
    chk("hex_busy", busy, 0);
    chk("hex_ovf", overflow, 0);
    tick();
    chk("hex_seg", seg_out, model_seg());
  endtask

  task automatic do_dec(input logic [DW-1:0] v);
    int n;
    wr_data = v; wr_mode = 1'b1; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n = 0;
    while (busy && n < 200) begin n++; tick(); end
    chk("dec_busy_cycles", n, DW);
    m_val = 64'(v); m_dec = 1'b1; m_valid = 1'b1;
    chk("dec_ovf", overflow, m_ovf());
    tick();
    chk("dec_seg", seg_out, model_seg());
  endtask

  initial begin
    int n, drops;
    logic [DW-1:0] v;
    m_val = 0; m_dec = 0; m_valid = 0;

    // Reset state and quiet period after release
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", seg_out, {7*ND{1'b1}});
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", wr_drop, 0);
    #4 rst = 1'b0;
    repeat (5) tick();
    chk("idle_seg", seg_out, {7*ND{1'b1}});

    // Hex 0x1A with leading-zero blanking
    blank_lz = 1'b1;
    do_hex(27'h1A);
    chk("t2_seg", seg_out, {{6{7'h7F}}, 7'h79, 7'h08});

    // Decimal 12345678, no blanking
    blank_lz = 1'b0;
    do_dec(27'd12345678);
    chk("t3_d0", seg_out[6:0], 7'h00);
    chk("t3_d7", seg_out[55:49], 7'h79);

    // Overflow shows dashes
    do_dec(27'd100000000);
    chk("t4_ovf", overflow, 1);
    chk("t4_dash", seg_out, {ND{7'h3F}});

    // Reset in the middle of a conversion
    wr_data = 27'd555; wr_mode = 1'b1; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    repeat (10) tick();
    chk("mid_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_seg", seg_out, {7*ND{1'b1}});
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", overflow, 0);
    #3 rst = 1'b0;
    m_valid = 1'b0; m_val = 0; m_dec = 0;
    repeat (30) tick();
    chk("mid_after_seg", seg_out, {7*ND{1'b1}});
    chk("mid_after_busy", busy, 0);

    // Decimal zero with blanking
    blank_lz = 1'b1;
    do_dec(27'd0);
    chk("t4b_seg", seg_out, {{7{7'h7F}}, 7'h40});

    // Hex write five cycles into a decimal conversion of 42
    wr_data = 27'd42; wr_mode = 1'b1; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n = 0; drops = 0;
    while (busy && n < 200) begin
      if (n == 4) begin wr_en = 1'b1; wr_mode = 1'b0; wr_data = 27'h1234; end
      n++;
      tick();
      wr_en = 1'b0;
      if (wr_drop) drops++;
      chk("t5_hold", seg_out, model_seg());
    end
    chk("t5_busy_cycles", n, DW);
    chk("t5_drops", drops, 1);
    m_val = 42; m_dec = 1'b1; m_valid = 1'b1;
    tick();
    chk("t5_seg", seg_out, {{6{7'h7F}}, 7'h19, 7'h24});
    chk("t5_model", seg_out, model_seg());

    // Write on the completing edge is dropped
    blank_lz = 1'b0;
    wr_data = 27'd987654; wr_mode = 1'b1; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    repeat (DW - 1) tick();
    chk("edge_busy", busy, 1);
    wr_en = 1'b1; wr_mode = 1'b0; wr_data = 27'h0ABCDEF;
    tick();
    wr_en = 1'b0;
    chk("edge_busy_done", busy, 0);
    chk("edge_drop", wr_drop, 1);
    m_val = 987654; m_dec = 1'b1; m_valid = 1'b1;
    tick();
    chk("edge_seg", seg_out, model_seg());
    tick();
    chk("edge_seg_hold", seg_out, model_seg());

    // Randomized writes
    for (int k = 0; k < 16; k++) begin
      v = (k % 2 == 1) ? DW'($urandom_range(0, 9999)) : DW'($urandom);
      blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) do_dec(v);
      else                           do_hex(v);
    end

    // Blink with a four-cycle half-period
    blank_lz = 1'b0;
    do_hex(27'h3);
    blink_mask = 8'h01;
    tick();
    for (int k = 0; k < 16; k++) begin
      tick();
      chk("blink_seg", seg_out, model_seg());
    end
    blink_mask = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_bank.md
Name: seven_seg_bank

Overview:
Parametrised successor to the fixed eight-port seven-segment export bank. It converts one binary value to NUM_DIGITS seven-segment patterns in hex or decimal mode. Decimal mode uses a sequential double-dabble conversion. The block adds leading-zero blanking, per-digit blink, overflow display and a busy handshake. It sits between the CPU-side register slave and the board HEX displays.

Parameters:
NUM_DIGITS, 8, number of digits driven (1..16)
DATA_W, 27, width of the input value (2..64)
BLINK_DIV, 25000000, clock cycles per blink half-period (>=2)
ACTIVE_LOW, 1, 1 = segment lit by driving 0 (DE2 HEX), 0 = lit by driving 1

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous reset, active-high
wr_en  in  1  write strobe; accepted only when busy=0
wr_data  in  DATA_W  unsigned value to display
wr_mode  in  1  0 = hex, 1 = decimal; sampled with wr_en
blank_lz  in  1  1 = blank leading zeros; sampled continuously
blink_mask  in  NUM_DIGITS  bit i=1 makes digit i blink; sampled continuously
busy  out  1  decimal conversion in progress
overflow  out  1  last accepted decimal value did not fit in NUM_DIGITS
wr_drop  out  1  one-cycle pulse: wr_en arrived while busy and was ignored
seg_out  out  7*NUM_DIGITS  digit i occupies bits [7i+6:7i], bit order g..a (bit6=g, bit0=a)

Behaviour:
- Single clock domain. Reset is asynchronous and active-high. All state lives in flops cleared by reset_reset.
- Reset values: seg_out all segments off (all 1s when ACTIVE_LOW=1), busy=0, overflow=0, wr_drop=0. Digit register is cleared and marked blank, blink counter=0, blink_phase=0.
- States: IDLE, CONV. Reset enters IDLE.
- Hex write, IDLE with wr_en=1 and wr_mode=0 (edge E0):
  - The digit register loads nibble i of wr_data zero-extended; nibbles beyond DATA_W are 0.
  - overflow is cleared. The state stays IDLE and busy is never asserted.
  - seg_out reflects the new value after edge E1.
- Decimal write, IDLE with wr_en=1 and wr_mode=1 (edge E0):
  - wr_data is latched and the BCD accumulator is cleared. The state goes to CONV and busy=1 after E0.
  - Each CONV cycle adds 3 to every BCD digit that is >=5, then shifts in one data bit, MSB first.
  - The conversion takes exactly DATA_W cycles. At edge E_DATA_W the state returns to IDLE and busy=0.
  - At the same edge the digit register loads the low NUM_DIGITS BCD digits. seg_out reflects the result after E_(DATA_W+1).
- BCD accumulator width: BCD_DIGITS = (DATA_W*301)/1000 + 1 digits. When BCD_DIGITS <= NUM_DIGITS the overflow logic is absent.
- Overflow: any BCD digit at index >= NUM_DIGITS is nonzero -> overflow=1 and every digit shows a dash (segment g only). blank_lz is ignored while overflow is shown; blink still applies.
- wr_en while busy (CONV): ignored, wr_drop=1 for one cycle, and the conversion continues unaffected.
- wr_en on the same edge that CONV completes: busy is still 1 at that edge, so the write is dropped.
- Leading-zero blanking (blank_lz=1): every digit above the most significant nonzero digit is blanked. Digit 0 is never blanked by this rule, so value 0 shows "0".
- Blink timing: a free-running counter runs 0..BLINK_DIV-1. blink_phase toggles when the counter wraps. While blink_phase=1, digits with blink_mask[i]=1 are blanked.
- Output register: seg_out is registered. A change on blank_lz or blink_mask appears one cycle later.
- Polarity: ACTIVE_LOW=1 inverts the active-high pattern.
- Hex glyphs: standard 0-9, A, b, C, d, E, F. Decimal digits use the same glyphs for 0-9.
- Reset asserted mid-conversion aborts immediately to the reset values; there is no partial result.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16-entry active-high glyph constants, plus SEG_DASH and SEG_BLANK;
  - the mode constants MODE_HEX and MODE_DEC;
  - the state enum {IDLE, CONV};
  - the function bcd_digits(DATA_W).
- One sub-module, bin2bcd_seq: the parametrised iterative double-dabble engine, with start/busy/done and a BCD output.
- The glyph lookup, blanking, blink logic and output register remain in seven_seg_bank.

Test Plan:
Defaults apply unless noted; values are per digit with ACTIVE_LOW=1.
1. Assert reset_reset mid-run -> seg_out = all 7'h7F immediately, busy=0, overflow=0; after release, no output change until a write.
2. Hex write 0x1A, blank_lz=1 -> busy stays 0; after E1, digit0=7'h08 ("A"), digit1=7'h79 ("1"), digits 2-7 = 7'h7F.
3. Decimal write 12345678, blank_lz=0 -> busy high for exactly 27 cycles; then digit7..digit0 = 1,2,3,4,5,6,7,8, with digit0=7'h00 and digit7=7'h79.
4. Decimal write 100000000 -> overflow=1 and all digits = 7'h3F. A following decimal write of 0 with blank_lz=1 -> overflow=0, digit0=7'h40, others 7'h7F.
5. Hex write issued 5 cycles into a decimal conversion of 42 -> wr_drop pulses once; the final display is "42" and the hex value never appears.
6. BLINK_DIV=4, hex write 0x3, blink_mask=8'h01 -> digit0 alternates 7'h30 / 7'h7F every 4 cycles while digits 1-7 stay constant.
